// File: rtl/dma_txll_pkg.sv
// dma_txll_pkg
// Shared definitions for the TX link-layer staging buffer:
//   - NPI entry width and the tag bit positions that carry SOF/EOF
//   - serializer state encoding
//   - debug word field offsets and the helpers that pack/unpack words
// No ports; imported by dma_txll_if, dma_txll_fifo and dma_txll.
package dma_txll_pkg;

    localparam int ENTRY_W     = 72;

    // Only these two tag bits carry meaning; the rest of d3p/d7p are ignored.
    localparam int TAG_SOF_BIT = 71;   // d3p[3], qualifies data0
    localparam int TAG_EOF_BIT = 66;   // d7p[2], qualifies data1

    // Debug word layout
    localparam int DBG_COUNT_LSB  = 0;
    localparam int DBG_STATE_LSB  = 8;
    localparam int DBG_INFRAME    = 10;
    localparam int DBG_OVF        = 11;
    localparam int DBG_FERR       = 12;
    localparam int DBG_FRAMES_LSB = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DW0  = 2'd1,
        S_DW1  = 2'd2
    } state_e;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] data0;
        logic [31:0] data1;
    } entry_t;

    // Extract the fields the serializer cares about from a raw NPI word.
    function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] word);
        entry_t e;
        e.sof   = word[TAG_SOF_BIT];
        e.eof   = word[TAG_EOF_BIT];
        e.data0 = word[63:32];
        e.data1 = word[31:0];
        return e;
    endfunction

    // Assemble the debug word; unlisted bits read as zero.
    function automatic logic [31:0] pack_dbg(
        input logic [7:0]  count,
        input logic [1:0]  st,
        input logic        in_frame,
        input logic        ovf,
        input logic        ferr,
        input logic [15:0] frames
    );
        logic [31:0] d;
        d = 32'h0000_0000;
        d[DBG_COUNT_LSB +: 8]   = count;
        d[DBG_STATE_LSB +: 2]   = st;
        d[DBG_INFRAME]          = in_frame;
        d[DBG_OVF]              = ovf;
        d[DBG_FERR]             = ferr;
        d[DBG_FRAMES_LSB +: 16] = frames;
        return d;
    endfunction

endpackage

// File: rtl/dma_txll_if.sv
// dma_txll_if
// Bundles the DMA-facing write/credit signals and the link-layer dword
// handshake of the TX staging buffer.
//   txdma2txll_do/push  : NPI entry write (no backpressure)
//   txll2txdma_rdy      : credit back to the DMA
//   ll_flush            : synchronous abort from the link layer
//   txll_data/sof/eof/valid, ll_ready : dword stream to the link layer
// Modports: slave = the staging buffer, master = DMA + link layer side.
interface dma_txll_if;
    import dma_txll_pkg::*;

    logic [ENTRY_W-1:0] txdma2txll_do;
    logic               txdma2txll_push;
    logic               txll2txdma_rdy;
    logic               ll_flush;
    logic [31:0]        txll_data;
    logic               txll_sof;
    logic               txll_eof;
    logic               txll_valid;
    logic               ll_ready;

    modport slave (
        input  txdma2txll_do,
        input  txdma2txll_push,
        input  ll_flush,
        input  ll_ready,
        output txll2txdma_rdy,
        output txll_data,
        output txll_sof,
        output txll_eof,
        output txll_valid
    );

    modport master (
        output txdma2txll_do,
        output txdma2txll_push,
        output ll_flush,
        output ll_ready,
        input  txll2txdma_rdy,
        input  txll_data,
        input  txll_sof,
        input  txll_eof,
        input  txll_valid
    );

endinterface

// File: rtl/dma_txll_fifo.sv
// dma_txll_fifo
// Synchronous 72-bit FIFO with occupancy count, sticky overflow and a
// registered free-space credit.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   flush              : synchronous clear (wins over push/pop)
//   push, wr_data      : write strobe and entry
//   pop                : consume the head entry (ignored when empty)
//   rd_data            : head entry (first-word fall-through)
//   empty, count       : occupancy
//   ovf                : sticky, set when a push is dropped
//   rdy                : free entries >= C_RDY_FREE, from post-update count
module dma_txll_fifo
    import dma_txll_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 64,
    parameter int C_RDY_FREE   = 32
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [ENTRY_W-1:0]            wr_data,
    input  logic                          pop,
    output logic [ENTRY_W-1:0]            rd_data,
    output logic                          empty,
    output logic [$clog2(C_FIFO_DEPTH):0] count,
    output logic                          ovf,
    output logic                          rdy
);

    localparam int AW = $clog2(C_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(C_FIFO_DEPTH);
    localparam logic [CW-1:0] RDY_C   = CW'(C_RDY_FREE);

    logic [ENTRY_W-1:0] mem_r [C_FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_r, wr_ptr_nx;
    logic [AW-1:0]      rd_ptr_r, rd_ptr_nx;
    logic [CW-1:0]      count_r, count_nx;
    logic               ovf_r, ovf_nx;
    logic               rdy_r, rdy_nx;
    logic               full_s, empty_s, pop_s, accept_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {CW{1'b0}});
    assign pop_s   = pop & ~empty_s & ~flush;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept_s = push & ~flush & (~full_s | pop_s);

    // Pointer, count, overflow and credit next-state
    always_comb begin
        wr_ptr_nx = wr_ptr_r;
        rd_ptr_nx = rd_ptr_r;
        count_nx  = count_r;
        ovf_nx    = ovf_r;
        if (flush) begin
            wr_ptr_nx = {AW{1'b0}};
            rd_ptr_nx = {AW{1'b0}};
            count_nx  = {CW{1'b0}};
            ovf_nx    = 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_nx = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nx = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nx = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nx = rd_ptr_r;
            end
            case ({accept_s, pop_s})
                2'b10:   count_nx = count_r + CNT_ONE;
                2'b01:   count_nx = count_r - CNT_ONE;
                default: count_nx = count_r;
            endcase
            if (push & ~accept_s) begin
                ovf_nx = 1'b1;
            end else begin
                ovf_nx = ovf_r;
            end
        end
        rdy_nx = ((DEPTH_C - count_nx) >= RDY_C);
    end

    // Control state registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            ovf_r    <= 1'b0;
            rdy_r    <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nx;
            rd_ptr_r <= rd_ptr_nx;
            count_r  <= count_nx;
            ovf_r    <= ovf_nx;
            rdy_r    <= rdy_nx;
        end
    end

    // Entry storage; contents need no reset since count gates every read
    always_ff @(posedge sys_clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign empty   = empty_s;
    assign count   = count_r;
    assign ovf     = ovf_r;
    assign rdy     = rdy_r;

endmodule

// File: rtl/dma_txll.sv
// dma_txll
// TX link-layer staging buffer. Buffers tagged 72-bit NPI entries from the
// TX DMA and serializes each into two 32-bit dwords (data0 then data1) with
// SOF/EOF framing, checking frame structure on the way out.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : NPI write + credit, link-layer dword handshake, flush
//   txll_ovf           : sticky, an entry was dropped on a full FIFO
//   txll_ferr          : sticky framing error (nested SOF or dword outside frame)
//   txll2dbg           : [7:0] count, [9:8] state, [10] in_frame, [11] ovf,
//                        [12] ferr, [31:16] frames sent
module dma_txll
    import dma_txll_pkg::*;
#(
    parameter int C_FIFO_DEPTH = 64,
    parameter int C_RDY_FREE   = 32
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    dma_txll_if.slave   bus,
    output logic        txll_ovf,
    output logic        txll_ferr,
    output logic [31:0] txll2dbg
);

    localparam int CW = $clog2(C_FIFO_DEPTH) + 1;

    logic [ENTRY_W-1:0] fifo_rd_s;
    logic               fifo_empty_s;
    logic [CW-1:0]      fifo_count_s;
    logic               fifo_ovf_s;
    logic               fifo_rdy_s;
    logic               pop_s;
    logic               xfer_s;
    entry_t             entry_s;

    state_e      state_r, state_nx;
    logic [31:0] data_r, data_nx;
    logic        sof_r, sof_nx;
    logic        eof_r, eof_nx;
    logic        valid_r, valid_nx;
    logic [31:0] hold_data1_r, hold_data1_nx;
    logic        hold_eof_r, hold_eof_nx;
    logic        in_frame_r, in_frame_nx;
    logic        ferr_r, ferr_nx;
    logic [15:0] frames_r, frames_nx;

    dma_txll_fifo #(
        .C_FIFO_DEPTH (C_FIFO_DEPTH),
        .C_RDY_FREE   (C_RDY_FREE)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .flush     (bus.ll_flush),
        .push      (bus.txdma2txll_push),
        .wr_data   (bus.txdma2txll_do),
        .pop       (pop_s),
        .rd_data   (fifo_rd_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .ovf       (fifo_ovf_s),
        .rdy       (fifo_rdy_s)
    );

    assign entry_s = unpack_entry(fifo_rd_s);
    assign xfer_s  = valid_r & bus.ll_ready;

    // Serializer next-state/next-output decode. data0 is presented straight
    // from the FIFO head on pop; data1 and its EOF tag wait in the holding
    // register so the head can advance immediately.
    always_comb begin
        state_nx      = state_r;
        data_nx       = data_r;
        sof_nx        = sof_r;
        eof_nx        = eof_r;
        valid_nx      = valid_r;
        hold_data1_nx = hold_data1_r;
        hold_eof_nx   = hold_eof_r;
        pop_s         = 1'b0;
        if (bus.ll_flush) begin
            state_nx = S_IDLE;
            valid_nx = 1'b0;
            sof_nx   = 1'b0;
            eof_nx   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s         = 1'b1;
                        state_nx      = S_DW0;
                        data_nx       = entry_s.data0;
                        sof_nx        = entry_s.sof;
                        eof_nx        = 1'b0;
                        valid_nx      = 1'b1;
                        hold_data1_nx = entry_s.data1;
                        hold_eof_nx   = entry_s.eof;
                    end else begin
                        state_nx = S_IDLE;
                        valid_nx = 1'b0;
                    end
                end
                S_DW0: begin
                    if (xfer_s) begin
                        state_nx = S_DW1;
                        data_nx  = hold_data1_r;
                        sof_nx   = 1'b0;
                        eof_nx   = hold_eof_r;
                    end else begin
                        state_nx = S_DW0;
                    end
                end
                S_DW1: begin
                    if (xfer_s) begin
                        if (!fifo_empty_s) begin
                            // Back-to-back entries: no idle bubble.
                            pop_s         = 1'b1;
                            state_nx      = S_DW0;
                            data_nx       = entry_s.data0;
                            sof_nx        = entry_s.sof;
                            eof_nx        = 1'b0;
                            valid_nx      = 1'b1;
                            hold_data1_nx = entry_s.data1;
                            hold_eof_nx   = entry_s.eof;
                        end else begin
                            state_nx = S_IDLE;
                            valid_nx = 1'b0;
                            sof_nx   = 1'b0;
                            eof_nx   = 1'b0;
                        end
                    end else begin
                        state_nx = S_DW1;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    valid_nx = 1'b0;
                    sof_nx   = 1'b0;
                    eof_nx   = 1'b0;
                end
            endcase
        end
    end

    // Frame tracking on each transferred dword. A nested SOF or a dword
    // outside a frame is flagged but the dword is still sent.
    always_comb begin
        in_frame_nx = in_frame_r;
        ferr_nx     = ferr_r;
        frames_nx   = frames_r;
        if (bus.ll_flush) begin
            in_frame_nx = 1'b0;
            ferr_nx     = 1'b0;
        end else if (xfer_s) begin
            if (sof_r) begin
                if (in_frame_r) begin
                    ferr_nx = 1'b1;
                end else begin
                    ferr_nx = ferr_r;
                end
                in_frame_nx = 1'b1;
            end else begin
                if (!in_frame_r) begin
                    ferr_nx = 1'b1;
                end else begin
                    ferr_nx = ferr_r;
                end
                if (eof_r) begin
                    in_frame_nx = 1'b0;
                    frames_nx   = frames_r + 16'd1;
                end else begin
                    in_frame_nx = in_frame_r;
                end
            end
        end else begin
            in_frame_nx = in_frame_r;
        end
    end

    // Serializer, output and framing registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= S_IDLE;
            data_r       <= 32'h0000_0000;
            sof_r        <= 1'b0;
            eof_r        <= 1'b0;
            valid_r      <= 1'b0;
            hold_data1_r <= 32'h0000_0000;
            hold_eof_r   <= 1'b0;
            in_frame_r   <= 1'b0;
            ferr_r       <= 1'b0;
            frames_r     <= 16'h0000;
        end else begin
            state_r      <= state_nx;
            data_r       <= data_nx;
            sof_r        <= sof_nx;
            eof_r        <= eof_nx;
            valid_r      <= valid_nx;
            hold_data1_r <= hold_data1_nx;
            hold_eof_r   <= hold_eof_nx;
            in_frame_r   <= in_frame_nx;
            ferr_r       <= ferr_nx;
            frames_r     <= frames_nx;
        end
    end

    assign bus.txll_data      = data_r;
    assign bus.txll_sof       = sof_r;
    assign bus.txll_eof       = eof_r;
    assign bus.txll_valid     = valid_r;
    assign bus.txll2txdma_rdy = fifo_rdy_s;
    assign txll_ovf           = fifo_ovf_s;
    assign txll_ferr          = ferr_r;
    assign txll2dbg           = pack_dbg(8'(fifo_count_s), state_r, in_frame_r,
                                         fifo_ovf_s, ferr_r, frames_r);

endmodule
